// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Streams a length-prefixed program into instruction memory and
//               holds the core in reset until the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    parameter int          RST_HOLD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_HOLD   = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [31:0] c_max_words = 32'(MAX_WORDS);
    localparam logic [7:0]  c_hold_last = 8'(RST_HOLD - 1);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        w_xfer;
    logic [15:0] w_len;

    assign w_xfer = in_valid & in_ready_q;
    assign w_len  = {in_data, len_q[7:0]};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        asm_d        = asm_q;
        hold_cnt_d   = hold_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            S_LEN_LO: begin
                if (w_xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    len_d      = w_len;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                    if (w_len == 16'd0 || {16'd0, w_len} > c_max_words) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    // Little-endian: bytes enter at the top and drift down.
                    asm_d      = {in_data, asm_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {in_data, asm_q};
                        imem_addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                        word_cnt_d   = word_cnt_q + 16'd1;
                        if (word_cnt_q == len_q - 16'd1) begin
                            state_d    = S_HOLD;
                            hold_cnt_d = 8'd0;
                        end
                    end
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (hold_cnt_q == c_hold_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_ERR: begin
            end
            default: state_d = S_ERR;
        endcase

        // Status outputs follow the next state so they are registered yet aligned.
        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
        core_rst_d = (state_d == S_RUN);
        done_d     = (state_d == S_RUN);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LEN_LO;
            len_q        <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= 16'd0;
            asm_q        <= 24'd0;
            hold_cnt_q   <= 8'd0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'd0;
            core_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            asm_q        <= asm_d;
            hold_cnt_q   <= hold_cnt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader (vector table plus
//               write scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    imem_boot_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024),
        .RST_HOLD  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          max_gap;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return 32'h1357_9BDF ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Write monitor: every strobe must match the oldest outstanding expectation.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("extra_we", {31'd0, imem_we}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("we_addr", imem_addr, e.addr);
                chk("we_data", imem_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 64) begin
            step();
            t++;
        end
        if (t >= 64) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_we", {31'd0, imem_we}, 32'd0);
        chk("idle_flags", {29'd0, core_rst, done, error}, 32'd0);
    endtask

    task automatic push_ignored(input logic exp_core_rst);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            step();
            chk("term_in_ready", {31'd0, in_ready}, 32'd0);
            chk("term_core_rst", {31'd0, core_rst}, {31'd0, exp_core_rst});
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        logic [31:0] w;
        wr_t         e;
        send_byte(v.n[7:0], $urandom_range(0, v.max_gap));
        send_byte(v.n[15:8], $urandom_range(0, v.max_gap));
        if (v.exp_err) begin
            chk("err_flags", {29'd0, core_rst, done, error}, 32'd1);
            chk("err_in_ready", {31'd0, in_ready}, 32'd0);
            push_ignored(1'b0);
            chk("err_sticky", {31'd0, error}, 32'd1);
        end else begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = word_of(v, i);
                e.addr = 32'(i) * 32'd4;
                e.data = w;
                sb.push_back(e);
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], $urandom_range(0, v.max_gap));
                end
            end
            // Now in the cycle of the final write strobe.
            chk("last_we", {31'd0, imem_we}, 32'd1);
            chk("last_in_ready", {31'd0, in_ready}, 32'd0);
            for (int c = 1; c < 4; c++) begin
                step();
                chk("hold_core_rst", {30'd0, core_rst, done}, 32'd0);
            end
            step();
            chk("run_core_rst", {31'd0, core_rst}, 32'd1);
            chk("run_done", {31'd0, done}, 32'd1);
            chk("sb_empty", 32'(sb.size()), 32'd0);
            sb.delete();
            push_ignored(1'b1);
        end
    endtask

    vec_t vecs[6];

    initial begin
        vec_t dbf;
        #500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t dbf;
        wr_t  e;
        vecs[0] = '{n: 16'd2,    w0: 32'h0050_0093, w1: 32'h00A0_0113, max_gap: 0, exp_err: 1'b0};
        vecs[1] = '{n: 16'd2,    w0: 32'h0050_0093, w1: 32'h00A0_0113, max_gap: 7, exp_err: 1'b0};
        vecs[2] = '{n: 16'd0,    w0: 32'h0,         w1: 32'h0,         max_gap: 0, exp_err: 1'b1};
        vecs[3] = '{n: 16'd1025, w0: 32'h0,         w1: 32'h0,         max_gap: 2, exp_err: 1'b1};
        vecs[4] = '{n: 16'd1024, w0: 32'hCAFE_F00D, w1: 32'h0BAD_BEEF, max_gap: 0, exp_err: 1'b0};
        vecs[5] = '{n: 16'd5,    w0: 32'hA5A5_5A5A, w1: 32'h0000_0001, max_gap: 3, exp_err: 1'b0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            run_load(vecs[v]);
        end

        // Abort a N=3 load after five data bytes; word 0 lands before the abort.
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        e.addr = 32'h0;
        e.data = 32'h4433_2211;
        sb.push_back(e);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_core_rst", {31'd0, core_rst}, 32'd0);
        chk("abort_we", {31'd0, imem_we}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        do_reset();
        dbf = '{n: 16'd1, w0: 32'hDEAD_BEEF, w1: 32'h0, max_gap: 1, exp_err: 1'b0};
        run_load(dbf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
